instr_encoder: RTL and testbench

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 149 ++++++++++++++
 tb/tb_instr_encoder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// Encodes RISC-V style R/I/S/B/U/J instruction fields into 32-bit words and queues them with error flags.
// Latency: 1 cycle from accept to FIFO head when empty; words are written on the accepting edge.
// Backpressure: in_ready drops only while the FIFO is full; out_instr/out_err hold while out_ready is low.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   in_valid/in_ready          request handshake
//   fmt, opcode, rd, rs1, rs2,
//   funct3, funct7, imm        instruction fields (fmt 0..5 = R,I,S,B,U,J; 6,7 illegal)
//   out_valid/out_ready        FIFO head handshake
//   out_instr, out_err         head word and flags {illegal, misaligned, range}
//   count                      FIFO occupancy
//   err_count                  saturating count of accepted flagged requests
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 fmt,
  input  logic [6:0]                 opcode,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [2:0]                 funct3,
  input  logic [6:0]                 funct7,
  input  logic [31:0]                imm,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [2:0]                 out_err,
  output logic [$clog2(DEPTH):0]     count,
  output logic [CNT_W-1:0]           err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  // ---------------- combinational encoder ----------------
  logic [31:0] enc_instr;
  logic        enc_rng;
  logic        enc_mis;
  logic        enc_ill;
  logic [2:0]  enc_err;
  logic signed [31:0] simm;

  assign simm = $signed(imm);

  always_comb begin
    enc_instr = 32'h0;
    enc_rng   = 1'b0;
    enc_mis   = 1'b0;
    enc_ill   = 1'b0;
    case (fmt)
      FMT_R: enc_instr = {funct7, rs2, rs1, funct3, rd, opcode};
      FMT_I: begin
        enc_instr = {imm[11:0], rs1, funct3, rd, opcode};
        enc_rng   = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_S: begin
        enc_instr = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_rng   = (simm < -32'sd2048) || (simm > 32'sd2047);
      end
      FMT_B: begin
        // imm[0] is not encodable; it is dropped and reported as misaligned
        enc_instr = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        enc_rng   = (simm < -32'sd4096) || (simm > 32'sd4094);
        enc_mis   = imm[0];
      end
      FMT_U: begin
        enc_instr = {imm[31:12], rd, opcode};
        enc_rng   = (imm[11:0] != 12'h0);
      end
      FMT_J: begin
        enc_instr = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        enc_rng   = (simm < -32'sd1048576) || (simm > 32'sd1048574);
        enc_mis   = imm[0];
      end
      default: enc_ill = 1'b1;  // word stays zero, other flags stay clear
    endcase
  end

  assign enc_err = {enc_ill, enc_mis, enc_rng};

  // ---------------- FIFO ----------------
  logic [34:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic push;
  logic pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_instr = out_valid ? mem_q[rd_ptr_q][31:0]  : 32'h0;
  assign out_err   = out_valid ? mem_q[rd_ptr_q][34:32] : 3'h0;
  assign count     = count_q;
  assign err_count = err_cnt_q;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    err_cnt_d = err_cnt_q;
    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (push && (enc_err != 3'h0) && (err_cnt_q != '1))
      err_cnt_d = err_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {enc_err, enc_instr};
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  localparam int DEPTH = 4;
  localparam int CNT_W = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [2:0]  out_err;
  logic [2:0]  count;
  logic [CNT_W-1:0] err_count;

  instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err),
    .count(count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [34:0] mq[$];     // reference queue of {err, instr}
  int merr = 0;           // reference error counter
  int bnd [16] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4097,
                   -4098, -1048576, 1048574, 1048575, 1048576, -1048577, 17};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bits(input logic [31:0] x, input int hi, input int lo);
    logic [31:0] m;
    m = (hi - lo == 31) ? 32'hFFFF_FFFF : ((32'h1 << (hi - lo + 1)) - 32'h1);
    return (x >> lo) & m;
  endfunction

  // Reference encoder: places immediate slices at their field positions by arithmetic.
  function automatic logic [34:0] ref_enc();
    int s;
    logic [31:0] w, op, r_d, r1, r2, f3, f7;
    logic [2:0] e;
    s = $signed(imm);
    op = 32'(opcode); r_d = 32'(rd) << 7; f3 = 32'(funct3) << 12;
    r1 = 32'(rs1) << 15; r2 = 32'(rs2) << 20; f7 = 32'(funct7) << 25;
    w = 32'h0; e = 3'b000;
    case (fmt)
      3'd0: w = f7 | r2 | r1 | f3 | r_d | op;
      3'd1: begin
        w = (bits(imm, 11, 0) << 20) | r1 | f3 | r_d | op;
        e[0] = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (bits(imm, 11, 5) << 25) | r2 | r1 | f3 | (bits(imm, 4, 0) << 7) | op;
        e[0] = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (bits(imm, 12, 12) << 31) | (bits(imm, 10, 5) << 25) | r2 | r1 | f3 |
            (bits(imm, 4, 1) << 8) | (bits(imm, 11, 11) << 7) | op;
        e[0] = (s < -4096) || (s > 4094);
        e[1] = (s % 2) != 0;
      end
      3'd4: begin
        w = (bits(imm, 31, 12) << 12) | r_d | op;
        e[0] = bits(imm, 11, 0) != 0;
      end
      3'd5: begin
        w = (bits(imm, 20, 20) << 31) | (bits(imm, 10, 1) << 21) | (bits(imm, 11, 11) << 20) |
            (bits(imm, 19, 12) << 12) | r_d | op;
        e[0] = (s < -1048576) || (s > 1048574);
        e[1] = (s % 2) != 0;
      end
      default: e = 3'b100;
    endcase
    return {e, w};
  endfunction

  // Check DUT against the model mid-cycle, then advance one clock and update the model.
  task automatic cycle();
    logic acc, pop;
    logic [34:0] e, head;
    @(negedge clk);
    head = (mq.size() != 0) ? mq[0] : 35'h0;
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("count", 32'(count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("out_instr", out_instr, head[31:0]);
    chk("out_err", 32'(out_err), 32'(head[34:32]));
    chk("err_count", 32'(err_count), 32'(merr));
    acc = in_valid && (mq.size() != DEPTH);
    pop = out_ready && (mq.size() != 0);
    e = ref_enc();
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(e);
      if (e[34:32] != 3'b000 && merr != (1 << CNT_W) - 1) merr++;
    end
    #1;
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
  endtask

  task automatic rand_req();
    logic [31:0] im;
    case ($urandom_range(0, 3))
      0: im = $urandom;
      1: im = 32'($urandom_range(0, 8191)) - 32'd4096;
      2: im = 32'(bnd[$urandom_range(0, 15)]);
      default: im = $urandom & 32'hFFFF_F000;
    endcase
    set_req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
            5'($urandom), 3'($urandom), 7'($urandom), im);
  endtask

  // One request into an empty FIFO; head must show the expected word one edge later.
  task automatic dir(input string tag, input logic [2:0] f, input logic [6:0] op,
                     input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                     input logic [2:0] f3, input logic [31:0] im,
                     input logic [31:0] exp_w, input logic [2:0] exp_e);
    set_req(f, op, d, s1, s2, f3, 7'h0, im);
    in_valid = 1'b1; out_ready = 1'b0;
    cycle();
    in_valid = 1'b0;
    chk({tag, "_instr"}, out_instr, exp_w);
    chk({tag, "_err"}, 32'(out_err), 32'(exp_e));
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_req(3'd0, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_err", 32'(out_err), 32'h0);
    chk("rst_count", 32'(count), 32'd0);
    #1 rst_n = 1'b1;

    // Known encodings
    dir("i_add", 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd10,         32'h00A10093, 3'b000);
    dir("s_sw",  3'd2, 7'h23, 5'd0, 5'd1, 5'd3, 3'd2, 32'd12,         32'h0030A623, 3'b000);
    dir("b_beq", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd16,         32'h00208863, 3'b000);
    dir("u_lui", 3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 32'h12345000,   32'h123450B7, 3'b000);
    dir("j_jal", 3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd32,         32'h020000EF, 3'b000);
    // Error flags
    dir("i_rng", 3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048,       32'h80010093, 3'b001);
    dir("b_mis", 3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd17,         32'h00208863, 3'b010);
    dir("ill",   3'd7, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd10,         32'h00000000, 3'b100);
    chk("err_count_3", 32'(err_count), 32'd3);

    // Fill while the consumer stalls, then drain
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (6) begin rand_req(); cycle(); end
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cycle();
    chk("drain_count", 32'(count), 32'd0);

    // Streaming across pointer wrap
    in_valid = 1'b1; out_ready = 1'b1;
    repeat (10) begin
      rand_req(); cycle();
      chk("stream_count_le1", 32'(count <= 3'd1), 32'd1);
    end

    // Random traffic
    repeat (600) begin
      rand_req();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      cycle();
    end

    // Reset with words queued
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (DEPTH + 1) cycle();
    in_valid = 1'b1; out_ready = 1'b0;
    set_req(3'd6, 7'h0, 5'h0, 5'h0, 5'h0, 3'h0, 7'h0, 32'h0);
    repeat (3) cycle();
    chk("pre_rst_count", 32'(count), 32'd3);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_err_count", 32'(err_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_out_instr", out_instr, 32'h0);
    mq.delete(); merr = 0;
    @(posedge clk); #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) cycle();
    // First edge after release accepts
    out_ready = 1'b0;
    set_req(3'd1, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 7'h0, 32'd10);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("post_rst_instr", out_instr, 32'h00A10093);
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
